instr_fetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the CPU decode/execute path.

---
 rtl/instr_fetch_queue_pkg.sv | 25 ++
 rtl/instr_fetch_queue_sync_fifo.sv | 62 ++++++
 rtl/instr_fetch_queue.sv | 120 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   INSTR_W          instruction / address width
//   PC_INC           byte increment between sequential fetches
//   RESET_PC_DEFAULT default first fetch address
//   fetch_entry_t    one prefetch-queue entry {pc, instr}
//   clog2()          pointer width helper for the FIFOs
package instr_fetch_queue_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and a combinational head read.
//   clk_i, rst_i  clock, asynchronous active-low reset of the pointers
//   push, din     write din when not full (ignored during flush)
//   pop           drop the head entry when not empty (ignored during flush)
//   flush         empty the FIFO on this edge
//   full, empty   occupancy flags
//   head          current head entry (meaningless while empty)
//   count         current occupancy, 0..DEPTH
module sync_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       head,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  // A word written at an edge is readable right after it: no output bubble.
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Storage carries data only; validity lives in the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: issues word reads to a variable-latency
// instruction memory, buffers the in-order responses and hands {instr, pc}
// to the decoder through a valid/ready handshake. Redirects flush the queue
// and discard reads that were already in flight.
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   imem_req_o, imem_addr_o          read request and word address
//   imem_gnt_i                       request accepted this cycle
//   imem_rvalid_i, imem_rdata_i      in-order read response
//   instr_valid_o, instr_o, instr_pc_o  queue head to the consumer
//   instr_ready_i                    consumer takes the head
//   redirect_i, redirect_pc_i        flush and restart at a new address
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [INSTR_W-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] instr_pc_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [INSTR_W-1:0] redirect_pc_i
);

  localparam int PW = clog2(DEPTH);

  logic [INSTR_W-1:0] fetch_pc;
  logic [PW:0]        outstanding;
  logic [PW:0]        discard;
  logic [PW:0]        q_count;
  logic [PW:0]        t_count;
  logic               q_full, q_empty, t_full, t_empty;
  fetch_entry_t       q_head;
  fetch_entry_t       q_din;
  logic [INSTR_W-1:0] t_head;
  logic [PW+1:0]      in_use;
  logic               issue, resp, keep, pop;

  // Every read in flight owns a queue slot, so responses can never overflow.
  assign in_use     = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_o = rst_i & ~redirect_i & (in_use < (PW+2)'(DEPTH));
  assign imem_addr_o = fetch_pc;

  assign issue = imem_req_o & imem_gnt_i;
  // A beat with nothing outstanding is a protocol error and is ignored.
  assign resp  = imem_rvalid_i & (outstanding != '0);
  assign keep  = resp & (discard == '0) & ~redirect_i;
  assign pop   = ~q_empty & instr_ready_i & ~redirect_i;

  assign q_din = '{pc: t_head, instr: imem_rdata_i};

  assign instr_valid_o = ~q_empty;
  assign instr_o       = q_empty ? '0 : q_head.instr;
  assign instr_pc_o    = q_empty ? '0 : q_head.pc;

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (keep),
    .pop   (pop),
    .flush (redirect_i),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head),
    .count (q_count)
  );

  // Tags only for reads that will be kept; stale reads are never tagged,
  // so a discarded beat does not pop this FIFO.
  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_tag_q (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (issue),
    .pop   (keep),
    .flush (redirect_i),
    .din   (fetch_pc),
    .full  (t_full),
    .empty (t_empty),
    .head  (t_head),
    .count (t_count)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (redirect_i)  fetch_pc <= redirect_pc_i & ~32'h3;
      else if (issue)  fetch_pc <= fetch_pc + PC_INC;

      outstanding <= outstanding + (PW+1)'(issue) - (PW+1)'(resp);

      // Everything still in flight after a redirect is stale. When a
      // redirect arrives with no grant since the previous one, this equals
      // the current discard count less the beat dropped this cycle.
      if (redirect_i)
        discard <= outstanding - (PW+1)'(resp);
      else if (resp && discard != '0)
        discard <= discard - (PW+1)'(1);
    end
  end

  a_rvalid_tracked : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(imem_rvalid_i && outstanding == '0));
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(keep && (q_full || t_empty)) && !(issue && t_full));
  a_tags_match : assert property (@(posedge clk_i) disable iff (!rst_i)
    (discard <= outstanding) && (t_count == outstanding - discard));

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: reads in flight (oldest first, with stale flag and the
  // cycle the memory answers) and the words the consumer should see.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    int          due;
    bit          stale;
  } rd_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  rd_t         inflight[$];
  ent_t        exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] popped[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int grants = 0;
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit   exp_req, exp_vld, issue, rv, pop;
    rd_t  r;
    imem_gnt_i    = ($urandom_range(0, 99) < gnt_pct);
    rv            = (inflight.size() > 0) && (inflight[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? mem_word(inflight[0].addr) : $urandom;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
    exp_req = !redir && (exp_q.size() + inflight.size() < 4);
    exp_vld = (exp_q.size() > 0);
    chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, model_pc);
    chk("valid", {31'b0, instr_valid_o}, {31'b0, exp_vld});
    if (exp_vld) begin
      chk("instr", instr_o, exp_q[0].instr);
      chk("pc", instr_pc_o, exp_q[0].pc);
    end
    if (imem_req_o && imem_gnt_i) grants++;
    issue = exp_req && imem_gnt_i;
    pop   = exp_vld && rdy && !redir;
    if (pop) popped.push_back(instr_pc_o);
    if (rv) r = inflight.pop_front();
    if (redir) begin
      exp_q.delete();
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      model_pc = rpc & ~32'h3;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (rv && !r.stale) exp_q.push_back('{pc: r.pc, instr: mem_word(r.addr)});
      if (issue) begin
        inflight.push_back('{pc: model_pc, addr: imem_addr_o,
                             due: cyc + $urandom_range(lat_min, lat_max), stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic idle_inputs();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
  endtask

  // Reset asserted off the clock edge: outputs must clear at once.
  task automatic do_reset();
    #2;
    idle_inputs();
    rst_i = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    inflight.delete();
    exp_q.delete();
    popped.delete();
    model_pc = 32'h0;
    grants   = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy);
  endtask

  task automatic chk_pop(input int idx, input logic [31:0] exp);
    chk("pop_count", {31'b0, popped.size() > idx}, 32'd1);
    if (popped.size() > idx) chk("pop_pc", popped[idx], exp);
  endtask

  initial begin
    rst_i = 1'b0;
    idle_inputs();
    @(negedge clk_i);
    do_reset();

    // Free run, 1-cycle latency.
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    run(12, 1'b1);
    chk_pop(0, 32'h0);  chk_pop(1, 32'h4);
    chk_pop(2, 32'h8);  chk_pop(3, 32'hC);

    // Consumer stalled: credit stops requests after DEPTH grants.
    do_reset();
    run(10, 1'b0);
    chk("stall_grants", grants, 32'd4);
    chk("stall_req", {31'b0, imem_req_o}, 32'd0);
    run(10, 1'b1);
    chk_pop(0, 32'h0);  chk_pop(1, 32'h4);
    chk_pop(2, 32'h8);  chk_pop(3, 32'hC);
    chk_pop(4, 32'h10);

    // Redirect with two slow reads in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    run(2, 1'b1);
    step(1'b1, 32'h103, 1'b1);
    popped.delete();
    run(12, 1'b1);
    chk_pop(0, 32'h100); chk_pop(1, 32'h104);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_min = 2; lat_max = 2;
    run(5, 1'b1);
    step(1'b1, 32'h40, 1'b1);
    chk("post_redir_valid", {31'b0, instr_valid_o}, 32'd0);
    popped.delete();
    run(10, 1'b1);
    chk_pop(0, 32'h40);

    // Address wrap.
    do_reset();
    lat_min = 1; lat_max = 1;
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    popped.delete();
    run(10, 1'b1);
    chk_pop(0, 32'hFFFF_FFF8); chk_pop(1, 32'hFFFF_FFFC); chk_pop(2, 32'h0);

    // Random traffic with occasional redirects.
    do_reset();
    gnt_pct = 60; lat_min = 1; lat_max = 4;
    begin
      bit last_redir;
      last_redir = 1'b0;
      for (int i = 0; i < 400; i++) begin
        bit rd;
        rd = !last_redir && ($urandom_range(0, 99) < 5);
        step(rd, $urandom, ($urandom_range(0, 99) < 70));
        last_redir = rd;
      end
    end

    // Reset while the queue holds words and reads are in flight.
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    run(5, 1'b0);
    chk("pre_rst_valid", {31'b0, instr_valid_o}, 32'd1);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    run(8, 1'b1);
    chk_pop(0, 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
